// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: inhibits the bus, issues a request,
// shifts one command byte out on device clock edges and checks the ACK.
// Ports: clk, rst (sync, active-high); tx_data/tx_valid/tx_ready request
// handshake; tx_done/tx_error 1-cycle result pulses; err_code (00 none,
// 01 timeout, 10 no ACK); host_busy; PS2_CLK/PS2_DATA open-drain (0 or Z).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  output logic       host_busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ?
                          INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] SET_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK_WAIT,
    S_RELEASE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [1:0]    err_q, err_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;

  // two-flop synchronizers plus a history flop for edge detection
  logic clk_m_q, clk_s_q, clk_p_q;
  logic dat_m_q, dat_s_q;

  logic       fall;
  logic       tmo;
  logic [9:0] frame;

  assign fall  = clk_p_q & ~clk_s_q;
  assign frame = {1'b1, par_q, data_q};
  assign tmo   = (tcnt_q == TMO_LAST) &&
                 (state_q inside {S_SEND, S_ACK_WAIT, S_RELEASE});

  assign PS2_CLK  = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DATA = dat_oe_q ? 1'b0 : 1'bz;

  assign tx_ready  = (state_q == S_IDLE);
  assign tx_done   = (state_q == S_DONE);
  assign tx_error  = (state_q == S_FAIL);
  assign host_busy = (state_q != S_IDLE);
  assign err_code  = err_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    bit_d    = bit_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;

    if ((state_q inside {S_SEND, S_ACK_WAIT, S_RELEASE}) &&
        !tmo && (tcnt_q != '1))
      tcnt_d = tcnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          data_d   = tx_data;
          par_d    = ~^tx_data;
          err_d    = 2'b00;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (cnt_q == SET_LAST) begin
          cnt_d    = '0;
          tcnt_d   = '0;
          bit_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = S_SEND;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (tmo) begin
          err_d    = 2'b01;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else if (fall) begin
          // a 1 bit (and the stop bit) is sent by releasing the line
          dat_oe_d = ~frame[bit_q];
          if (bit_q == 4'd9)
            state_d = S_ACK_WAIT;
          else
            bit_d = bit_q + 1'b1;
        end
      end
      S_ACK_WAIT: begin
        if (tmo) begin
          err_d    = 2'b01;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else if (fall) begin
          if (!dat_s_q) begin
            state_d = S_RELEASE;
          end else begin
            err_d    = 2'b10;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_FAIL;
          end
        end
      end
      S_RELEASE: begin
        if (tmo) begin
          err_d    = 2'b01;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_FAIL;
        end else if (clk_s_q && dat_s_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      err_q    <= 2'b00;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      bit_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      clk_m_q  <= 1'b1;
      clk_s_q  <= 1'b1;
      clk_p_q  <= 1'b1;
      dat_m_q  <= 1'b1;
      dat_s_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      bit_q    <= bit_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      clk_m_q  <= PS2_CLK;
      clk_s_q  <= clk_m_q;
      clk_p_q  <= clk_s_q;
      dat_m_q  <= PS2_DATA;
      dat_s_q  <= dat_m_q;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
// Shortened timing parameters keep the run small.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int SET  = 8;
  localparam int TMO  = 600;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;
  logic       host_busy;
  wire        ps2_clk;
  wire        ps2_data;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .err_code  (err_code),
    .host_busy (host_busy),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  int  n_done = 0;
  int  n_fail = 0;
  int  n_both = 0;
  int  n_acc = 0;
  time t_rel;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (tx_done === 1'b1) n_done++;
      if (tx_error === 1'b1) n_fail++;
      if (tx_done === 1'b1 && tx_error === 1'b1) n_both++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) n_acc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device side: waits for the request, then clocks `edges` falling
  // edges, reading the line at each rising edge.
  task automatic run_frame(input int edges, input bit ack,
                           output logic [9:0] bits,
                           output int inh, output int setc);
    int k;
    bits = '0;
    k = 0;
    while (ps2_clk !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    inh = 0;
    while (ps2_clk === 1'b0 && ps2_data === 1'b1 && inh < 5000) begin
      inh++;
      @(negedge clk);
    end
    setc = 0;
    while (ps2_clk === 1'b0 && ps2_data === 1'b0 && setc < 5000) begin
      setc++;
      @(negedge clk);
    end
    t_rel = $time;
    for (int e = 1; e <= edges; e++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e-1] = ps2_data;
      if (e == 10 && ack) dev_data_low = 1'b1;
      if (e == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  logic [9:0] bits;
  int inh, setc, d0, f0, k;

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", tx_ready, 1);
    chk("rst_done_err", {tx_done, tx_error}, 0);
    chk("rst_errcode", err_code, 0);
    chk("rst_busy", host_busy, 0);
    chk("rst_lines", {ps2_clk, ps2_data}, 2'b11);

    // 0xED with ACK
    d0 = n_done; f0 = n_fail;
    request(8'hED);
    chk("ed_ready_low", tx_ready, 0);
    chk("ed_busy", host_busy, 1);
    run_frame(11, 1'b1, bits, inh, setc);
    chk("ed_inhibit", inh, INH);
    chk("ed_setup", setc, SET);
    chk("ed_data", bits[7:0], 8'hED);
    chk("ed_par_stop", bits[9:8], 2'b11);
    repeat (20) @(negedge clk);
    chk("ed_done", n_done - d0, 1);
    chk("ed_noerr", n_fail - f0, 0);
    chk("ed_errcode", err_code, 0);
    chk("ed_ready", tx_ready, 1);
    chk("ed_busy_off", host_busy, 0);

    // 0xF4
    d0 = n_done;
    request(8'hF4);
    run_frame(11, 1'b1, bits, inh, setc);
    chk("f4_data", bits[7:0], 8'hF4);
    chk("f4_par_stop", bits[9:8], 2'b10);
    repeat (20) @(negedge clk);
    chk("f4_done", n_done - d0, 1);

    // 0x00
    d0 = n_done;
    request(8'h00);
    run_frame(11, 1'b1, bits, inh, setc);
    chk("z0_data", bits[7:0], 8'h00);
    chk("z0_par_stop", bits[9:8], 2'b11);
    repeat (20) @(negedge clk);
    chk("z0_done", n_done - d0, 1);

    // no ACK
    d0 = n_done; f0 = n_fail;
    request(8'h55);
    run_frame(11, 1'b0, bits, inh, setc);
    chk("nak_data", bits[7:0], 8'h55);
    repeat (20) @(negedge clk);
    chk("nak_err", n_fail - f0, 1);
    chk("nak_nodone", n_done - d0, 0);
    chk("nak_errcode", err_code, 2'b10);
    chk("nak_lines", {ps2_clk, ps2_data}, 2'b11);
    chk("nak_ready", tx_ready, 1);

    // timeout after 4 device edges
    d0 = n_done; f0 = n_fail;
    request(8'hA3);
    run_frame(4, 1'b0, bits, inh, setc);
    k = 0;
    while (tx_error !== 1'b1 && k < 2 * TMO) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", 32'(($time - t_rel) / 10), TMO);
    chk("tmo_errcode", err_code, 2'b01);
    repeat (5) @(negedge clk);
    chk("tmo_err", n_fail - f0, 1);
    chk("tmo_nodone", n_done - d0, 0);
    chk("tmo_lines", {ps2_clk, ps2_data}, 2'b11);

    // valid held high: one frame per accept
    d0 = n_done; f0 = n_acc;
    @(negedge clk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h02;
    run_frame(11, 1'b1, bits, inh, setc);
    chk("hold_acc1", n_acc - f0, 1);
    chk("hold_data1", bits, {2'b11, 8'h11});
    k = 0;
    while (tx_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("hold_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    run_frame(11, 1'b1, bits, inh, setc);
    chk("hold_data2", bits, {2'b10, 8'h02});
    repeat (20) @(negedge clk);
    chk("hold_acc2", n_acc - f0, 2);
    chk("hold_done", n_done - d0, 2);

    // reset during SEND after 5 edges
    d0 = n_done; f0 = n_fail;
    request(8'h00);
    run_frame(5, 1'b0, bits, inh, setc);
    chk("mid_pre_data", ps2_data, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_lines", {ps2_clk, ps2_data}, 2'b11);
    chk("mid_ready", tx_ready, 1);
    chk("mid_busy", host_busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_pulses", {n_done - d0, n_fail - f0}, 0);

    d0 = n_done;
    request(8'hFF);
    run_frame(11, 1'b1, bits, inh, setc);
    chk("ff_frame", bits, {2'b11, 8'hFF});
    repeat (20) @(negedge clk);
    chk("ff_done", n_done - d0, 1);
    chk("ff_errcode", err_code, 0);

    chk("never_both", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the send direction of the keyboard link that the game's keyboard decoder receives on.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs (dark-stage indicator), 0xFF reset, 0xF4 enable.
- Shares PS2_CLK/PS2_DATA with the receive decoder. Drives each line only low or high-Z (open-drain).
- Reports device ACK, missing ACK, or timeout.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low before the request (100 us at 100 MHz).
- SETUP_CYCLES, 200, clk cycles PS2_DATA is held low with PS2_CLK still low before PS2_CLK is released.
- TIMEOUT_CYCLES, 2000000, maximum clk cycles from clock release to end of transfer (20 ms).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tx_data  input  8  command byte
- tx_valid  input  1  request; accepted when tx_ready=1
- tx_ready  output  1  idle, can accept a byte
- tx_done  output  1  1-cycle pulse, transfer completed with ACK
- tx_error  output  1  1-cycle pulse, transfer failed
- err_code  output  2  00 none, 01 timeout, 10 no ACK; held until next accept
- host_busy  output  1  high whenever not IDLE; receive decoder ignores frames while high
- PS2_CLK  inout  1  driven 0 or Z only
- PS2_DATA  inout  1  driven 0 or Z only

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Both PS/2 lines pass through a 2-flop synchronizer. Falling edge = synchronized prev 1, now 0.
- Reset values: both lines Z, tx_ready=1, tx_done=0, tx_error=0, err_code=00, host_busy=0, state IDLE, counters 0.
- Reset mid-transfer releases both lines on the same edge; no done/error pulse.
- Frame: start 0, d0..d7 LSB first, odd parity (~^tx_data), stop 1, then device ACK 0.
- IDLE:
  - tx_valid & tx_ready: latch byte, compute parity, clear err_code.
  - Next cycle: tx_ready=0, go INHIBIT.
  - tx_valid while not ready is ignored; no queue.
- INHIBIT: drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, then go REQ.
- REQ:
  - Drive PS2_DATA low (start bit) while PS2_CLK stays low, for SETUP_CYCLES cycles.
  - Then release PS2_CLK, clear timeout counter, bit_idx=0, go SEND.
- SEND:
  - On each PS2_CLK falling edge, present bit[bit_idx]: 0 means drive low, 1 means Z. Index 0-7 data, 8 parity, 9 stop (Z).
  - Data changes only in the cycle after an edge is detected.
  - After the edge that presents stop, go ACK_WAIT.
- ACK_WAIT (PS2_DATA released):
  - On next falling edge, sample synchronized PS2_DATA.
  - 0 means ACK: go RELEASE.
  - 1 means no ACK: err_code=10, go FAIL.
- RELEASE: wait until synchronized PS2_CLK=1 and PS2_DATA=1, then go DONE.
- DONE: tx_done=1 for one cycle, tx_ready=1 next cycle, go IDLE.
- FAIL: release both lines, tx_error=1 for one cycle, go IDLE.
- Timeout:
  - Counter runs in SEND, ACK_WAIT and RELEASE.
  - Reaching TIMEOUT_CYCLES-1 forces err_code=01 and goes FAIL. Timeout takes priority over an edge in the same cycle.
- tx_done and tx_error are never high together.
- A new request cannot be accepted in the DONE or FAIL cycle.
- Counters are sized to hold their parameter value; counters saturate, they never wrap.

Test Plan:
- 0xED, device model clocks 11 falling edges and pulls data low on the 11th:
  - PS2_CLK low for 10000 cycles, then data low 200 cycles.
  - Data bits sampled at device rising edges read 1,0,1,1,0,1,1,1.
  - Parity 1, stop 1.
  - tx_done pulses once, err_code=00, tx_ready returns.
- 0xF4: data bits 0,0,1,0,1,1,1,1, parity 0. Also 0x00: parity 1. Confirm both frames.
- Device never pulls ACK low: tx_error pulse, err_code=10, both lines Z afterward.
- Device stops clocking after 4 edges: tx_error exactly TIMEOUT_CYCLES after clock release, err_code=01, lines released.
- tx_valid held high through a transfer with second byte 0x02: only one frame sent per accept; second accepted only after tx_ready=1 and framed correctly.
- rst asserted mid-SEND (bit_idx=5): next edge both lines Z, tx_ready=1, no pulses; following 0xFF transfer completes with parity 1.
